// File: rtl/left_rotate_reg_pkg.sv
// Shared definitions for the left-rotate register: default width and a
// reusable rotate-left-by-one helper usable by any block up to MAX_DW bits.
package left_rotate_reg_pkg;

  localparam int DW_DEFAULT = 4;
  localparam int MAX_DW     = 64;

  // Width-generic rotate: bits at and above w are returned as zero, so a
  // caller truncates the result back to its own width.
  function automatic logic [MAX_DW-1:0] rotl1(input logic [MAX_DW-1:0] v,
                                              input int unsigned       w);
    logic [MAX_DW-1:0] r;
    r = '0;
    for (int i = 1; i < MAX_DW; i++) begin
      if (i < int'(w)) r[i] = v[i-1];
    end
    for (int i = 0; i < MAX_DW; i++) begin
      if (i == int'(w) - 1) r[0] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/left_rotate_reg.sv
// Parallel-load register that rotates left by one bit per enabled cycle.
// Priority at each edge: reset, load, rotate, hold.
module left_rotate_reg
  import left_rotate_reg_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q
);

  logic [DW-1:0] q_q;
  logic [DW-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = data;
    end else if (en) begin
      q_d = DW'(rotl1(MAX_DW'(q_q), DW));
    end
  end

  // Reset is checked here rather than in q_d so it dominates every request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: tb/tb_left_rotate_reg.sv
// Bench for left_rotate_reg: directed vectors with literal expectations plus
// a per-cycle comparison against an arithmetic reference model.
module tb_left_rotate_reg;

  localparam int DW = 4;

  logic          clk;
  logic          rst_n;
  logic          load;
  logic          en;
  logic [DW-1:0] data;
  logic [DW-1:0] q;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model;
  bit            model_valid = 1'b0;

  left_rotate_reg #(.DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .en    (en),
    .data  (data),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: q=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: rotation as shift-and-or arithmetic on a plain vector.
  always @(posedge clk) begin
    if (!rst_n) begin
      model       = '0;
      model_valid = 1'b1;
    end else if (load) begin
      model = data;
    end else if (en) begin
      model = (model << 1) | (model >> (DW - 1));
    end
  end

  always @(negedge clk) begin
    if (model_valid) check("model", q, model);
  end

  task automatic drive(input logic r, input logic l, input logic e,
                       input logic [DW-1:0] d);
    rst_n = r;
    load  = l;
    en    = e;
    data  = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();

    // Reset wins over load
    drive(1'b0, 1'b1, 1'b0, 4'b1010);
    tick();
    check("reset", q, 4'b0000);

    // Load then hold while data wanders
    drive(1'b1, 1'b1, 1'b0, 4'b1011);
    tick();
    check("load", q, 4'b1011);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, DW'($urandom));
      tick();
      check("hold", q, 4'b1011);
    end

    // Rotate and wrap
    drive(1'b1, 1'b0, 1'b1, 4'b0000);
    tick(); check("rot1", q, 4'b0111);
    tick(); check("rot2", q, 4'b1110);
    tick(); check("rot3", q, 4'b1101);
    tick(); check("wrap", q, 4'b1011);

    // Reach 1101, then load beats rotate
    tick(); tick(); tick();
    check("pre_prio", q, 4'b1101);
    drive(1'b1, 1'b1, 1'b1, 4'b0110);
    tick(); check("load_prio", q, 4'b0110);
    drive(1'b1, 1'b0, 1'b1, 4'b0000);
    tick(); check("rot_after_load", q, 4'b1100);

    // Reset asserted between edges must wait for the edge
    drive(1'b0, 1'b1, 1'b1, 4'b0101);
    #2;
    check("sync_reset_wait", q, 4'b1100);
    tick(); check("reset_mid_rot", q, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 4'b1001);
    tick(); check("load_after_reset", q, 4'b1001);

    // Glitch on load between edges is ignored
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    #2;
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    tick(); check("between_edges", q, 4'b1001);

    // All-ones and all-zeros are rotation-invariant
    drive(1'b1, 1'b1, 1'b0, 4'b1111);
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'b0000);
    tick(); tick(); check("ones_rot", q, 4'b1111);
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 1'b1, 4'b1111);
    tick(); tick(); check("zeros_rot", q, 4'b0000);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [DW-1:0] d;
      case ($urandom_range(0, 5))
        0:       d = '0;
        1:       d = '1;
        default: d = DW'($urandom);
      endcase
      drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1) == 1, d);
      tick();
    end

    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
